// File: rtl/demux14_pkg.sv
// rtl/demux14_pkg.sv - shared types and constants for the 1-to-4 stream demultiplexer
package demux14_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

endpackage

// File: rtl/demux14_slot.sv
// rtl/demux14_slot.sv - one-entry output register with valid/ready and beat counter
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   load       write load_data into the register this cycle (only when can_load)
//   load_data  beat to store
//   out_ready  consumer ready
//   out_valid  register holds a beat
//   out_data   stored beat, held after drain
//   beat_cnt   wrapping count of delivered beats
//   can_load   register is empty or is being drained this cycle
module demux14_slot #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             can_load
);

    assign can_load = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            beat_cnt  <= '0;
        end else begin
            // A load in the same cycle as a drain replaces the beat and keeps valid high.
            if (load) begin
                out_data  <= load_data;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (out_valid && out_ready) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux14_stream.sv
// rtl/demux14_stream.sv - 1-to-4 registered stream demultiplexer with optional frame lock
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   in_data    input beat data
//   in_sel     destination channel 0..3
//   in_last    last beat of frame (only used when DEMUX_FRAME_LOCK_EN is defined)
//   in_valid   input beat valid
//   in_ready   input beat accepted when in_valid & in_ready
//   out_data   channel i data at out_data[i*WIDTH +: WIDTH]
//   out_valid  per-channel valid
//   out_ready  per-channel ready
//   beat_cnt   channel i delivered-beat count at beat_cnt[i*CNT_W +: CNT_W]
//
// Build option: DEMUX_FRAME_LOCK_EN keeps every beat of a frame on the channel
// chosen by its first beat.
module demux14_stream
    import demux14_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [1:0]              in_sel,
    input  logic                    in_last,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [4*WIDTH-1:0]      out_data,
    output logic [3:0]              out_valid,
    input  logic [3:0]              out_ready,
    output logic [4*CNT_W-1:0]      beat_cnt
);

    sel_t              dest;
    logic              accept;
    logic [NUM_CH-1:0] can_load;
    logic [NUM_CH-1:0] load;

`ifdef DEMUX_FRAME_LOCK_EN
    lock_state_t state_q, state_n;
    sel_t        lock_sel_q, lock_sel_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= UNLOCKED;
            lock_sel_q <= '0;
        end else begin
            state_q    <= state_n;
            lock_sel_q <= lock_sel_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        lock_sel_n = lock_sel_q;
        case (state_q)
            UNLOCKED: begin
                // A single-beat frame (in_last on its first beat) never locks.
                if (accept && !in_last) begin
                    state_n    = LOCKED;
                    lock_sel_n = in_sel;
                end
            end
            LOCKED: begin
                if (accept && in_last) begin
                    state_n = UNLOCKED;
                end
            end
            default: state_n = UNLOCKED;
        endcase
    end

    always_comb begin
        dest = in_sel;
        if (state_q == LOCKED) begin
            dest = lock_sel_q;
        end
    end
`else
    logic unused_last;
    assign unused_last = in_last;
    assign dest        = in_sel;
`endif

    // Readiness depends only on the addressed channel, so a stalled channel
    // never holds up beats for the others.
    assign in_ready = !rst && can_load[dest];
    assign accept   = in_valid && in_ready;

    always_comb begin
        load = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            load[i] = accept && (dest == sel_t'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
        demux14_slot #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load[g]),
            .load_data (in_data),
            .out_ready (out_ready[g]),
            .out_valid (out_valid[g]),
            .out_data  (out_data[g*WIDTH +: WIDTH]),
            .beat_cnt  (beat_cnt[g*CNT_W +: CNT_W]),
            .can_load  (can_load[g])
        );
    end

endmodule
